// File: rtl/cordic_quad_prerot.sv
// CORDIC quadrant pre-rotation: folds the target angle into [-pi/2, pi/2) by an
// exact +/-pi/2 vector rotation, behind a one-deep output register plus skid slot.
module cordic_quad_prerot #(
  parameter int XY_W      = 16,
  parameter int ANGLE_W   = 32,
  parameter int EN_PREROT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [XY_W-1:0]    x_in,
  input  logic signed [XY_W-1:0]    y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [XY_W-1:0]    x_out,
  output logic signed [XY_W-1:0]    y_out,
  output logic signed [ANGLE_W-1:0] z_out,
  output logic [1:0]                quad_out,
  output logic                      sat_out
);

  localparam logic signed [XY_W-1:0]    XY_MIN  = {1'b1, {(XY_W-1){1'b0}}};
  localparam logic signed [XY_W-1:0]    XY_MAX  = {1'b0, {(XY_W-1){1'b1}}};
  localparam logic signed [ANGLE_W-1:0] QUARTER = {2'b01, {(ANGLE_W-2){1'b0}}};

  typedef struct packed {
    logic signed [XY_W-1:0]    x;
    logic signed [XY_W-1:0]    y;
    logic signed [ANGLE_W-1:0] z;
    logic [1:0]                quad;
    logic                      sat;
  } beat_t;

  // MSB of the result flags that the most-negative value was clipped.
  function automatic logic [XY_W:0] neg_sat(input logic signed [XY_W-1:0] v);
    if (v == XY_MIN) return {1'b1, XY_MAX};
    return {1'b0, -v};
  endfunction

  function automatic beat_t prerot(input logic signed [XY_W-1:0]    x,
                                   input logic signed [XY_W-1:0]    y,
                                   input logic signed [ANGLE_W-1:0] z);
    beat_t           b;
    logic [XY_W:0]   n;
    b.x    = x;
    b.y    = y;
    b.z    = z;
    b.quad = 2'b00;
    b.sat  = 1'b0;
    n      = '0;
    if (EN_PREROT != 0) begin
      case (z[ANGLE_W-1 -: 2])
        2'b01: begin
          n      = neg_sat(y);
          b.x    = n[XY_W-1:0];
          b.y    = x;
          b.z    = z - QUARTER;
          b.quad = 2'b01;
          b.sat  = n[XY_W];
        end
        2'b10: begin
          n      = neg_sat(x);
          b.x    = y;
          b.y    = n[XY_W-1:0];
          b.z    = z + QUARTER;
          b.quad = 2'b10;
          b.sat  = n[XY_W];
        end
        default: ;
      endcase
    end
    return b;
  endfunction

  beat_t beat_p0;
  beat_t skid_p0;
  beat_t main_p1;
  logic  skid_vld_p0;
  logic  vld_p1;
  logic  accept;
  logic  main_free;
  logic  load_main;
  logic  load_skid;
  logic  vld_p1_nxt;
  logic  skid_vld_nxt;

  assign beat_p0 = prerot(x_in, y_in, z_in);

  always_comb begin
    accept       = in_valid & in_ready;
    main_free    = ~vld_p1 | out_ready;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    vld_p1_nxt   = vld_p1;
    skid_vld_nxt = skid_vld_p0;
    if (main_free) begin
      // Skid holds the older beat, so it always wins the refill.
      load_main    = skid_vld_p0 | accept;
      vld_p1_nxt   = skid_vld_p0 | accept;
      load_skid    = skid_vld_p0 & accept;
      skid_vld_nxt = skid_vld_p0 & accept;
    end else begin
      load_skid    = accept;
      skid_vld_nxt = skid_vld_p0 | accept;
    end
  end

  // p0 -> skid slot
  always_ff @(posedge clk) begin
    if (load_skid) skid_p0 <= beat_p0;
  end

  // p0/skid -> p1 output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
      in_ready    <= 1'b0;
      main_p1     <= '0;
    end else begin
      vld_p1      <= vld_p1_nxt;
      skid_vld_p0 <= skid_vld_nxt;
      in_ready    <= ~skid_vld_nxt;
      if (load_main) main_p1 <= skid_vld_p0 ? skid_p0 : beat_p0;
    end
  end

  assign out_valid = vld_p1;
  assign x_out     = main_p1.x;
  assign y_out     = main_p1.y;
  assign z_out     = main_p1.z;
  assign quad_out  = main_p1.quad;
  assign sat_out   = main_p1.sat;

endmodule

// File: tb/tb_cordic_quad_prerot.sv
// Bench for cordic_quad_prerot: directed corner beats plus randomized traffic
// with backpressure, checked by a queue scoreboard against an integer model.
module tb_cordic_quad_prerot;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic signed [31:0] z_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [31:0] z_out;
  logic [1:0]         quad_out;
  logic               sat_out;

  int checks   = 0;
  int failures = 0;
  logic [66:0] exp_q[$];
  bit rnd_done;

  cordic_quad_prerot #(.XY_W(16), .ANGLE_W(32), .EN_PREROT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .quad_out(quad_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Angle read as a signed integer; a quarter turn is 2^30.
  function automatic logic [66:0] model(input int x, input int y, input int z);
    int         nx, ny, nz;
    logic [1:0] q;
    bit         s;
    nx = x; ny = y; nz = z; q = 2'b00; s = 1'b0;
    if (z >= 1073741824) begin
      nx = -y; ny = x; nz = z - 1073741824; q = 2'b01;
    end else if (z < -1073741824) begin
      nx = y; ny = -x; nz = z + 1073741824; q = 2'b10;
    end
    if (nx > 32767) begin nx = 32767; s = 1'b1; end
    if (ny > 32767) begin ny = 32767; s = 1'b1; end
    return {nx[15:0], ny[15:0], nz[31:0], q, s};
  endfunction

  function automatic logic [66:0] dut_beat();
    return {x_out, y_out, z_out, quad_out, sat_out};
  endfunction

  function automatic logic signed [15:0] rnd_xy();
    if ($urandom_range(7) == 0) return 16'sh8000;
    return 16'($urandom);
  endfunction

  // Holds the beat on the inputs until accepted; returns #1 after the accepting edge.
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic [31:0] z);
    int guard = 0;
    x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("send_timeout", 67'(in_ready), 67'd1);
    end else begin
      exp_q.push_back(model(x, y, z));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every output transfer and checks hold-while-stalled.
  initial begin
    logic [66:0] held;
    bit          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 67'(out_valid), 67'd1);
          chk("stall_hold", dut_beat(), held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", dut_beat(), 67'h0);
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got a beat with empty scoreboard");
          end else begin
            chk("beat", dut_beat(), exp_q.pop_front());
          end
        end
        stalled = out_valid && !out_ready;
        held    = dut_beat();
      end
    end
  end

  initial begin
    int cnt;
    logic [66:0] snap;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; rnd_done = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 67'(out_valid), 67'd0);
    chk("rst_in_ready", 67'(in_ready), 67'd0);
    chk("rst_outputs", dut_beat(), 67'd0);
    step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", 67'(in_ready), 67'd1);

    // Quadrant rotations with exact one-cycle latency
    out_ready = 1'b1;
    send(16'sd1000, 16'sd0, 32'h6000_0000);
    chk("lat_plus90", 67'(out_valid), 67'd1);
    chk("plus90", dut_beat(), {16'sd0, 16'sd1000, 32'h2000_0000, 2'b01, 1'b0});
    send(16'sd1000, 16'sd0, 32'hA000_0000);
    chk("lat_minus90", 67'(out_valid), 67'd1);
    chk("minus90", dut_beat(), {16'sd0, -16'sd1000, 32'hE000_0000, 2'b10, 1'b0});
    send(16'sd7, -16'sd3, 32'h4000_0000);
    chk("bnd_4000", dut_beat(), {16'sd3, 16'sd7, 32'h0000_0000, 2'b01, 1'b0});
    send(16'sd7, -16'sd3, 32'hC000_0000);
    chk("bnd_C000", dut_beat(), {16'sd7, -16'sd3, 32'hC000_0000, 2'b00, 1'b0});
    send(16'sd7, -16'sd3, 32'h8000_0000);
    chk("bnd_8000", dut_beat(), {-16'sd3, -16'sd7, 32'hC000_0000, 2'b10, 1'b0});
    send(16'sd5, -16'sd32768, 32'h5000_0000);
    chk("sat_set", dut_beat(), {16'sd32767, 16'sd5, 32'h1000_0000, 2'b01, 1'b1});
    send(16'sd5, -16'sd4, 32'h5000_0000);
    chk("sat_clear", dut_beat(), {16'sd4, 16'sd5, 32'h1000_0000, 2'b01, 1'b0});
    step();

    // Four beats against a 3-cycle stall
    out_ready = 1'b0;
    fork
      begin
        send(16'sd11, 16'sd12, 32'h1000_0000);
        send(16'sd21, 16'sd22, 32'h5000_0000);
        send(16'sd31, 16'sd32, 32'hB000_0000);
        send(16'sd41, 16'sd42, 32'hF000_0000);
      end
    join_none
    step();
    step();
    chk("bp_in_ready_low", 67'(in_ready), 67'd0);
    chk("bp_first_held", dut_beat(), {16'sd11, 16'sd12, 32'h1000_0000, 2'b00, 1'b0});
    snap = dut_beat();
    step();
    chk("bp_still_low", 67'(in_ready), 67'd0);
    chk("bp_stable", dut_beat(), snap);
    out_ready = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("bp_throughput", 67'(cnt), 67'd4);
    @(negedge clk);
    chk("bp_drained", 67'(out_valid), 67'd0);
    step();

    // Reset with both storage slots occupied
    out_ready = 1'b0;
    send(16'sd101, 16'sd102, 32'h0100_0000);
    send(16'sd201, 16'sd202, 32'h0200_0000);
    chk("full_in_ready", 67'(in_ready), 67'd0);
    rst = 1'b1;
    step();
    exp_q.delete();
    chk("mid_rst_valid", 67'(out_valid), 67'd0);
    chk("mid_rst_ready", 67'(in_ready), 67'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_ready", 67'(in_ready), 67'd1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("post_rst_no_beats", 67'(cnt), 67'd0);
    step();

    // Randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) step();
          send(rnd_xy(), rnd_xy(), $urandom());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      step();
      cnt++;
    end
    chk("rnd_all_delivered", 67'(exp_q.size()), 67'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
